// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
`timescale 1ns/1ps
// Purpose : capture sequencer between the JESD204 TPL ADC core and the DMA (arm, sync, align, bounded capture).
// Latency : adc_valid is combinational from registered state (zero added latency); status/pulses are registered.
// Backpres: none; valids are gated, not stalled; DMA overflow is only recorded in ovf_sticky.
//
// Ports:
//   clk, rst                 link clock, synchronous active-high reset
//   arm, abort               single-cycle control requests
//   ext_sync_en, align_en    wait for external_sync rising edge / link SOF before capturing
//   capture_len              beats to capture (0 = unbounded)
//   external_sync            external trigger (clk domain)
//   link_valid, link_sof     link beat qualifier and start-of-frame (bit 0 only)
//   core_valid, enable       per-channel valids from the core and enables from the register map
//   adc_dovf                 DMA overflow
//   adc_valid                gated per-channel valids to the DMA
//   adc_rst_sync             one-cycle core resync pulse on trigger
//   sync_status, capturing   waiting for trigger/alignment, capture in progress
//   capture_done             one-cycle pulse when a bounded capture completes
//   ovf_sticky, beat_count   overflow seen and beats passed in the current/last capture
module ad_ip_jesd204_tpl_adc_capture_ctrl #(
  parameter int NUM_CHANNELS    = 4,
  parameter int OCTETS_PER_BEAT = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       ext_sync_en,
  input  logic                       align_en,
  input  logic [COUNT_WIDTH-1:0]     capture_len,
  input  logic                       external_sync,
  input  logic                       link_valid,
  input  logic [OCTETS_PER_BEAT-1:0] link_sof,
  input  logic [NUM_CHANNELS-1:0]    core_valid,
  input  logic [NUM_CHANNELS-1:0]    enable,
  input  logic                       adc_dovf,
  output logic [NUM_CHANNELS-1:0]    adc_valid,
  output logic                       adc_rst_sync,
  output logic                       sync_status,
  output logic                       capturing,
  output logic                       capture_done,
  output logic                       ovf_sticky,
  output logic [COUNT_WIDTH-1:0]     beat_count
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_ARMED   = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    ext_sync_q, ext_sync_d;
  logic [COUNT_WIDTH-1:0]  beat_count_q, beat_count_d;
  logic                    ovf_sticky_q, ovf_sticky_d;
  logic                    adc_rst_sync_q, adc_rst_sync_d;
  logic                    capture_done_q, capture_done_d;

  logic [NUM_CHANNELS-1:0] enabled_vld;
  logic                    pass_en;
  logic                    beat;
  logic                    ext_edge;
  logic                    trigger;
  logic [COUNT_WIDTH-1:0]  count_inc;
  logic                    unused_sof;

  // Only the first octet's SOF flag marks the frame boundary we align to.
  assign unused_sof  = ^link_sof;

  assign enabled_vld = core_valid & enable;
  assign pass_en     = (state_q == ST_RUN) || (state_q == ST_CAPTURE);
  assign beat        = (state_q == ST_CAPTURE) && (|enabled_vld);
  assign ext_edge    = external_sync & ~ext_sync_q;
  assign trigger     = ~ext_sync_en | ext_edge;
  assign ext_sync_d  = external_sync;

  // Saturating increment so an unbounded capture never wraps back to a small count.
  assign count_inc = (&beat_count_q) ? beat_count_q
                                     : beat_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d        = state_q;
    beat_count_d   = beat_count_q;
    ovf_sticky_d   = ovf_sticky_q;
    adc_rst_sync_d = 1'b0;
    capture_done_d = 1'b0;

    case (state_q)
      ST_ARMED: begin
        if (trigger) begin
          state_d        = align_en ? ST_ALIGN : ST_CAPTURE;
          adc_rst_sync_d = 1'b1;
        end
      end
      ST_ALIGN: begin
        // The SOF beat itself is not captured; capture opens on the next cycle.
        if (link_valid && link_sof[0]) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (adc_dovf) begin
          ovf_sticky_d = 1'b1;
        end
        if (beat) begin
          beat_count_d = count_inc;
          if ((capture_len != '0) && (count_inc == capture_len)) begin
            state_d        = ST_HOLD;
            capture_done_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase

    // arm restarts from any state and wipes the previous capture's results.
    if (arm) begin
      state_d        = ST_ARMED;
      beat_count_d   = '0;
      ovf_sticky_d   = 1'b0;
      adc_rst_sync_d = 1'b0;
      capture_done_d = 1'b0;
    end

    // abort outranks arm; results of the interrupted capture stay visible.
    if (abort && (state_q != ST_RUN)) begin
      state_d        = ST_RUN;
      beat_count_d   = beat_count_q;
      ovf_sticky_d   = ovf_sticky_q;
      adc_rst_sync_d = 1'b0;
      capture_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      ext_sync_q     <= 1'b0;
      beat_count_q   <= '0;
      ovf_sticky_q   <= 1'b0;
      adc_rst_sync_q <= 1'b0;
      capture_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ext_sync_q     <= ext_sync_d;
      beat_count_q   <= beat_count_d;
      ovf_sticky_q   <= ovf_sticky_d;
      adc_rst_sync_q <= adc_rst_sync_d;
      capture_done_q <= capture_done_d;
    end
  end

  assign adc_valid    = enabled_vld & {NUM_CHANNELS{pass_en}};
  assign adc_rst_sync = adc_rst_sync_q;
  assign sync_status  = (state_q == ST_ARMED) || (state_q == ST_ALIGN);
  assign capturing    = (state_q == ST_CAPTURE);
  assign capture_done = capture_done_q;
  assign ovf_sticky   = ovf_sticky_q;
  assign beat_count   = beat_count_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for the ADC capture sequencer.
// Latency : expectations are queued per cycle by the stimulus and consumed by a negedge monitor.
// Backpres: none; the monitor pops one record on every cycle the DUT presents an event.
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

  typedef struct packed {
    logic [3:0]  vld;
    logic        rs;
    logic        dn;
    logic        ss;
    logic        cp;
    logic        ov;
    logic [15:0] cnt;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        abort;
  logic        ext_sync_en;
  logic        align_en;
  logic [15:0] capture_len;
  logic        external_sync;
  logic        link_valid;
  logic [3:0]  link_sof;
  logic [3:0]  core_valid;
  logic [3:0]  enable;
  logic        adc_dovf;
  logic [3:0]  adc_valid;
  logic        adc_rst_sync;
  logic        sync_status;
  logic        capturing;
  logic        capture_done;
  logic        ovf_sticky;
  logic [15:0] beat_count;

  logic        probe;
  ev_t         exp_q[$];
  int          checks;
  int          errors;

  ad_ip_jesd204_tpl_adc_capture_ctrl #(
    .NUM_CHANNELS   (4),
    .OCTETS_PER_BEAT(4),
    .COUNT_WIDTH    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .ext_sync_en  (ext_sync_en),
    .align_en     (align_en),
    .capture_len  (capture_len),
    .external_sync(external_sync),
    .link_valid   (link_valid),
    .link_sof     (link_sof),
    .core_valid   (core_valid),
    .enable       (enable),
    .adc_dovf     (adc_dovf),
    .adc_valid    (adc_valid),
    .adc_rst_sync (adc_rst_sync),
    .sync_status  (sync_status),
    .capturing    (capturing),
    .capture_done (capture_done),
    .ovf_sticky   (ovf_sticky),
    .beat_count   (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: any visible output event (valid beat, pulse or an explicit probe) consumes one record.
  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    act = '{vld: adc_valid, rs: adc_rst_sync, dn: capture_done, ss: sync_status,
            cp: capturing, ov: ovf_sticky, cnt: beat_count};
    if ((adc_valid != 4'b0000) || adc_rst_sync || capture_done || probe) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_event t=%0t vld=%b rs=%b dn=%b ss=%b cp=%b ov=%b cnt=%0d",
                 $time, act.vld, act.rs, act.dn, act.ss, act.cp, act.ov, act.cnt);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors = errors + 1;
          $display("FAIL event t=%0t got vld=%b rs=%b dn=%b ss=%b cp=%b ov=%b cnt=%0d want vld=%b rs=%b dn=%b ss=%b cp=%b ov=%b cnt=%0d",
                   $time, act.vld, act.rs, act.dn, act.ss, act.cp, act.ov, act.cnt,
                   e.vld, e.rs, e.dn, e.ss, e.cp, e.ov, e.cnt);
        end
      end
    end
  end

  task automatic push(input logic [3:0] v, input logic rs, input logic dn, input logic ss,
                      input logic cp, input logic ov, input int cnt);
    ev_t e;
    e.vld = v;
    e.rs  = rs;
    e.dn  = dn;
    e.ss  = ss;
    e.cp  = cp;
    e.ov  = ov;
    e.cnt = cnt[15:0];
    exp_q.push_back(e);
  endtask

  // Forces the monitor to sample this cycle even when no output event is present.
  task automatic probe_push(input logic [3:0] v, input logic rs, input logic dn, input logic ss,
                            input logic cp, input logic ov, input int cnt);
    push(v, rs, dn, ss, cp, ov, cnt);
    probe = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    probe    = 1'b0;
    arm      = 1'b0;
    abort    = 1'b0;
    adc_dovf = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    probe         = 1'b0;
    rst           = 1'b1;
    arm           = 1'b0;
    abort         = 1'b0;
    ext_sync_en   = 1'b0;
    align_en      = 1'b0;
    capture_len   = 16'd0;
    external_sync = 1'b0;
    link_valid    = 1'b0;
    link_sof      = 4'b0000;
    core_valid    = 4'b0000;
    enable        = 4'b1011;
    adc_dovf      = 1'b0;
    repeat (3) tick();

    // Reset state: pass-through immediately, all status low.
    rst = 1'b0;
    core_valid = 4'b1111;
    push(4'b1011, 0, 0, 0, 0, 0, 0);
    tick();

    // Bounded capture of 5 beats, no sync, no align.
    capture_len = 16'd5;
    arm = 1'b1;
    push(4'b1011, 0, 0, 0, 0, 0, 0);
    tick();
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      push(4'b1011, (i == 0), 0, 0, 1, 0, i);
      tick();
    end
    push(4'b0000, 0, 1, 0, 0, 0, 5);
    tick();
    core_valid = 4'b0000;
    probe_push(4'b0000, 0, 0, 0, 0, 0, 5);
    tick();

    // External sync + SOF alignment, 3 beats from a toggling source.
    ext_sync_en = 1'b1;
    align_en = 1'b1;
    capture_len = 16'd3;
    external_sync = 1'b1;
    tick();
    arm = 1'b1;
    tick();
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    external_sync = 1'b0;
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    external_sync = 1'b1;
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    push(4'b0000, 1, 0, 1, 0, 0, 0);
    tick();
    link_valid = 1'b1;
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    link_sof = 4'b0001;
    core_valid = 4'b1111;
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    link_valid = 1'b0;
    link_sof = 4'b0000;
    for (int j = 0; j < 5; j++) begin
      core_valid = (j % 2 == 0) ? 4'b1111 : 4'b0000;
      if (j % 2 == 0) push(4'b1011, 0, 0, 0, 1, 0, (j + 1) / 2);
      else probe_push(4'b0000, 0, 0, 0, 1, 0, (j + 1) / 2);
      tick();
    end
    core_valid = 4'b1111;
    push(4'b0000, 0, 1, 0, 0, 0, 3);
    tick();
    core_valid = 4'b0000;
    external_sync = 1'b0;
    ext_sync_en = 1'b0;
    align_en = 1'b0;

    // Unbounded capture of 20 beats, then abort.
    capture_len = 16'd0;
    arm = 1'b1;
    probe_push(4'b0000, 0, 0, 0, 0, 0, 3);
    tick();
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    core_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      push(4'b1011, (i == 0), 0, 0, 1, 0, i);
      tick();
    end
    core_valid = 4'b0000;
    abort = 1'b1;
    probe_push(4'b0000, 0, 0, 0, 1, 0, 20);
    tick();
    core_valid = 4'b1111;
    push(4'b1011, 0, 0, 0, 0, 0, 20);
    tick();
    core_valid = 4'b0110;
    push(4'b0010, 0, 0, 0, 0, 0, 20);
    tick();
    core_valid = 4'b0000;

    // Overflow sticky: set mid-capture, held in HOLD, cleared by arm; then arm+abort together.
    capture_len = 16'd4;
    arm = 1'b1;
    probe_push(4'b0000, 0, 0, 0, 0, 0, 20);
    tick();
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    core_valid = 4'b1111;
    push(4'b1011, 1, 0, 0, 1, 0, 0);
    tick();
    adc_dovf = 1'b1;
    push(4'b1011, 0, 0, 0, 1, 0, 1);
    tick();
    push(4'b1011, 0, 0, 0, 1, 1, 2);
    tick();
    push(4'b1011, 0, 0, 0, 1, 1, 3);
    tick();
    core_valid = 4'b0000;
    push(4'b0000, 0, 1, 0, 0, 1, 4);
    tick();
    arm = 1'b1;
    probe_push(4'b0000, 0, 0, 0, 0, 1, 4);
    tick();
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    arm = 1'b1;
    abort = 1'b1;
    push(4'b0000, 1, 0, 0, 1, 0, 0);
    tick();
    core_valid = 4'b0011;
    push(4'b0011, 0, 0, 0, 0, 0, 0);
    tick();
    core_valid = 4'b0000;

    // Reset while in ALIGN with an SOF present: back to RUN, no resync, no capture.
    align_en = 1'b1;
    arm = 1'b1;
    probe_push(4'b0000, 0, 0, 0, 0, 0, 0);
    tick();
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    push(4'b0000, 1, 0, 1, 0, 0, 0);
    tick();
    rst = 1'b1;
    link_valid = 1'b1;
    link_sof = 4'b0001;
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    rst = 1'b0;
    link_valid = 1'b0;
    link_sof = 4'b0000;
    probe_push(4'b0000, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset mid-capture clears the beat count and returns to pass-through.
    align_en = 1'b0;
    capture_len = 16'd0;
    arm = 1'b1;
    probe_push(4'b0000, 0, 0, 0, 0, 0, 0);
    tick();
    probe_push(4'b0000, 0, 0, 1, 0, 0, 0);
    tick();
    core_valid = 4'b1111;
    push(4'b1011, 1, 0, 0, 1, 0, 0);
    tick();
    push(4'b1011, 0, 0, 0, 1, 0, 1);
    tick();
    rst = 1'b1;
    push(4'b1011, 0, 0, 0, 1, 0, 2);
    tick();
    rst = 1'b0;
    push(4'b1011, 0, 0, 0, 0, 0, 0);
    tick();
    core_valid = 4'b0000;
    tick();
    tick();

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL missing_events got %0d events left in queue, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
